mem_stage: RTL
==============

Name: mem_stage

Overview:
- Data-memory stage directly downstream of the ALU stage in the MIPS datapath.
- Consumes the ALU result as the effective address and the register-file B operand as store data.
- Performs one word or byte load/store per request against an internal synchronous RAM, with a configurable number of wait states.
- Request/ready handshake lets the control FSM stall until the access completes.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words).
- WAIT_STATES, 2, extra idle cycles inserted before the RAM access; 0..15 legal.
- BASE_ADDR, 32'h0000_0400, byte address mapped to RAM word 0.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- Mem_Req  input  1  access request; sampled only in IDLE.
- Mem_WrEn  input  1  1 = store, 0 = load; sampled with Mem_Req.
- ByteOp  input  1  1 = byte access, 0 = word access; sampled with Mem_Req.
- ALU_MEM_Addr  input  32  byte address (ALU stage output).
- MEM_DataIn  input  32  store data (RF_B); byte stores use bits [7:0].
- MEM_DataOut  output  32  load result; held until the next load completes.
- Mem_Busy  output  1  high from acceptance until the cycle before Mem_Ready.
- Mem_Ready  output  1  one-cycle completion pulse.

Behaviour:
- Reset: async, active-low. Forces IDLE; MEM_DataOut=0, Mem_Busy=0, Mem_Ready=0; wait counter=0. RAM contents are not cleared.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - Mem_Req=1 at an edge latches address, data, WrEn and ByteOp, and sets Mem_Busy=1.
  - Next state is WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else ACCESS.
- WAIT: counter decrements each cycle; at 0 goes to ACCESS.
- ACCESS:
  - The RAM read or write occurs at this edge.
  - Loads register MEM_DataOut.
  - Mem_Busy drops; next state is DONE.
- DONE: Mem_Ready=1 for exactly one cycle; next state is IDLE.
  - A new Mem_Req is not accepted in DONE.
  - Earliest back-to-back acceptance is the edge after DONE.
- Latency: request accepted at edge k gives Mem_Ready high during the cycle after edge k+WAIT_STATES+1, i.e. WAIT_STATES+2 cycles after acceptance.
- Mem_Req while not in IDLE is ignored, with no queuing.
- Address map: offset = ALU_MEM_Addr - BASE_ADDR (32-bit, wraps); word index = offset[DEPTH_LOG2+1:2].
- Out of range: offset >= 4*2^DEPTH_LOG2, including underflow. Stores are dropped; loads return 0; handshake timing is unchanged.
- Word load: MEM_DataOut = RAM[index]; offset[1:0] is ignored.
- Word store: RAM[index] = latched data.
- Byte load: zero-extended byte lane offset[1:0], little-endian (lane 0 = bits [7:0]).
- Byte store: only lane offset[1:0] of RAM[index] is written, with data[7:0]; the other lanes are unchanged.
- Stores leave MEM_DataOut unchanged.
- Reset asserted before the ACCESS edge: no RAM write happens. Reset at the same edge as ACCESS is treated as reset winning, so no write.
- Inputs change freely after acceptance; only the latched copies are used.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output port Mem_Fault (1 bit, reset 0).
  - A word access with offset[1:0]!=0 suppresses the store or forces the load result to 0.
  - Mem_Fault pulses high in the same cycle as Mem_Ready.
  - Byte accesses never fault.
- When undefined: the port is absent and offset[1:0] is silently ignored for word accesses.

Test Plan:
- WAIT_STATES=2: word store 32'hDEADBEEF to 32'h0000_0400, then word load from the same address. MEM_DataOut=32'hDEADBEEF; Mem_Ready 4 cycles after each acceptance; Mem_Busy high for 3 cycles.
- Store word 32'h11223344 at 32'h0000_0408, then byte store 8'hAA to 32'h0000_040A. Word load returns 32'h11AA3344; byte load of 32'h0000_040B returns 32'h00000011.
- Out-of-range: store to 32'h0000_0000 and to 32'h0000_1400, then loads. Both loads return 0; RAM word 0 and word 1023 are unchanged.
- Mem_Req held high continuously for 3 requests. Accepted every WAIT_STATES+3 cycles; exactly one Mem_Ready pulse per access; requests during WAIT or DONE are ignored.
- Reset_n pulled low during WAIT of a store of 32'hCAFEF00D to 32'h0000_0410. Outputs go to 0 immediately; a subsequent load returns the prior contents, not 32'hCAFEF00D.
- With MEM_MISALIGN_TRAP_EN defined: word load at 32'h0000_0402 gives Mem_Fault=1 with Mem_Ready and MEM_DataOut=0. A byte load at the same address gives Mem_Fault=0.

Source files
------------

// File: rtl/mem_stage.sv
// Data-memory stage: one word/byte load or store per request against an internal
// synchronous RAM, with WAIT_STATES idle cycles. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_Req,
  input  logic        Mem_WrEn,
  input  logic        ByteOp,
  input  logic [31:0] ALU_MEM_Addr,
  input  logic [31:0] MEM_DataIn,
  output logic [31:0] MEM_DataOut,
  output logic        Mem_Busy,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        Mem_Fault,
`endif
  output logic        Mem_Ready
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, data_q;
  logic        wr_q, byte_q;

  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  in_range, misalign, accept, do_access;
  logic [31:0]           ram_word, load_val, store_word;

  logic [31:0] ram [2**DEPTH_LOG2];

  assign accept    = (state_q == S_IDLE) && Mem_Req;
  assign do_access = (state_q == S_ACCESS);

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (Mem_Req) state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_q == '0) state_d = S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request capture, wait counter and load result
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      MEM_DataOut <= '0;
    end else begin
      if (accept) begin
        addr_q <= ALU_MEM_Addr;
        data_q <= MEM_DataIn;
        wr_q   <= Mem_WrEn;
        byte_q <= ByteOp;
        cnt_q  <= WS_INIT;
      end else if (state_q == S_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (do_access && !wr_q) MEM_DataOut <= load_val;
    end
  end

  // Address decode; subtraction wraps so addresses below BASE_ADDR fall out of range
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (offset[31:DEPTH_LOG2+2] == '0);
  assign idx      = offset[DEPTH_LOG2+1:2];
  assign lane     = offset[1:0];
  assign ram_word = ram[idx];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = !byte_q && (lane != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    load_val = '0;
    if (in_range && !misalign) begin
      if (byte_q) load_val = {24'h0, ram_word[{lane, 3'b000} +: 8]};
      else        load_val = ram_word;
    end
  end

  always_comb begin
    store_word = data_q;
    if (byte_q) begin
      store_word = ram_word;
      store_word[{lane, 3'b000} +: 8] = data_q[7:0];
    end
  end

  // NOTE: RAM contents are deliberately not reset; the Reset_n term only blocks a write
  // on an edge where reset is asserted together with ACCESS.
  always_ff @(posedge Clk) begin
    if (do_access && wr_q && in_range && !misalign && Reset_n) ram[idx] <= store_word;
  end

  // Output decode
  assign Mem_Busy  = (state_q == S_WAIT) || (state_q == S_ACCESS);
  assign Mem_Ready = (state_q == S_DONE);
`ifdef MEM_MISALIGN_TRAP_EN
  assign Mem_Fault = (state_q == S_DONE) && misalign;
`endif

endmodule
